serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the nibble-serial adder controller.
// The requester (master) drives start and the operands; the adder (slave)
// returns status and the registered result.
interface serial_add_ctrl_if #(
   parameter int W = 16
);
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   modport master (
      output start, a, b, c_in,
      input  busy, done, sum, c_out, ovf
   );

   modport slave (
      input  start, a, b, c_in,
      output busy, done, sum, c_out, ovf
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder controller.
// A single 4-bit ripple slice is time-shared over NIBBLES cycles to add two
// W-bit operands. Operands are captured when a start is accepted in IDLE, so
// the bus may change freely while the operation runs. The result, carry-out
// and signed overflow are registered and held until the next accepted start.
module serial_add_ctrl #(
   parameter int NIBBLES = 4,          // legal range 2..8
   parameter int W       = 4*NIBBLES   // derived; keep at its default
) (
   input  logic             clk,
   input  logic             reset,
   serial_add_ctrl_if.slave bus
);

   localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     a_lat;
   logic [W-1:0]     b_lat;
   logic [W-1:0]     sum_r;
   logic             busy_r;
   logic             done_r;
   logic             c_out_r;
   logic             ovf_r;

   // One full-adder bit: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

   // The shared 4-bit slice: four chained full-adder bits fed from the
   // currently selected nibble of each latched operand and the carry register.
   logic [3:0] nib_a;
   logic [3:0] nib_b;
   logic [3:0] slice_sum;
   logic       c1;
   logic       c2;
   logic       c3;   // carry into the slice MSB; on the last nibble this is the carry into bit W-1
   logic       c4;   // slice carry-out

   assign nib_a = a_lat[4*idx +: 4];
   assign nib_b = b_lat[4*idx +: 4];

   assign {c1, slice_sum[0]} = full_add(nib_a[0], nib_b[0], carry);
   assign {c2, slice_sum[1]} = full_add(nib_a[1], nib_b[1], c1);
   assign {c3, slice_sum[2]} = full_add(nib_a[2], nib_b[2], c2);
   assign {c4, slice_sum[3]} = full_add(nib_a[3], nib_b[3], c3);

   // Operand capture: pure data, no reset needed, loaded only on acceptance.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.start) begin
         a_lat <= bus.a;
         b_lat <= bus.b;
      end
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         idx     <= '0;
         carry   <= 1'b0;
         sum_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  carry   <= bus.c_in;
                  idx     <= '0;
                  sum_r   <= '0;
                  c_out_r <= 1'b0;
                  ovf_r   <= 1'b0;
                  busy_r  <= 1'b1;
                  state   <= S_ADD;
               end
            end
            S_ADD: begin
               sum_r[4*idx +: 4] <= slice_sum;
               carry             <= c4;
               if (idx == LAST_IDX) begin
                  // Index parks on the last nibble; it is re-cleared on the next start.
                  c_out_r <= c4;
                  ovf_r   <= c3 ^ c4;
                  done_r  <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               // A start seen here is deliberately dropped.
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.sum   = sum_r;
   assign bus.c_out = c_out_r;
   assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: scenario tasks drive stimulus,
// expected results go into a scoreboard queue and are compared on done.
module tb_serial_add_ctrl;

   localparam int NIB    = 4;
   localparam int W      = 4*NIB;
   localparam int LAT    = NIB + 1;   // cycles from the start cycle to the done cycle
   localparam int PERIOD = NIB + 2;

   logic clk = 1'b0;
   logic reset;

   serial_add_ctrl_if #(.W(W)) bus();

   serial_add_ctrl #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [W:0] t;
      exp_t       e;
      t       = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.sum   = t[W-1:0];
      e.c_out = t[W];
      e.ovf   = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return e;
   endfunction

   // Scoreboard: every done pulse pops one expectation and compares the result.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         exp_t e;
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: got done=1 sum=%h, required no done pulse", bus.sum);
         end else begin
            e = exp_q.pop_front();
            if ({bus.c_out, bus.ovf, bus.sum} !== {e.c_out, e.ovf, e.sum}) begin
               failures++;
               $display("FAIL result: got sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                        bus.sum, bus.c_out, bus.ovf, e.sum, e.c_out, e.ovf);
            end
         end
      end
   end

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      bus.a     = x;
      bus.b     = y;
      bus.c_in  = ci;
      bus.start = 1'b1;
      exp_q.push_back(model(x, y, ci));
   endtask

   // Drive one start and wait (bounded) for done; returns the observed latency
   // and leaves the bench on a negedge with the DUT back in IDLE.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, output int lat);
      launch(x, y, ci);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.start = 1'b0;
      end while (bus.done !== 1'b1 && lat < 20);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy  !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", bus.busy);   end
      checks++; if (bus.done  !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", bus.done);   end
      checks++; if (bus.sum   !== '0)   begin failures++; $display("FAIL reset_sum: got %h, required 0", bus.sum);     end
      checks++; if (bus.c_out !== 1'b0) begin failures++; $display("FAIL reset_c_out: got %b, required 0", bus.c_out); end
      checks++; if (bus.ovf   !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf);     end
      reset = 1'b0;   // next task starts immediately: first edge after release
   endtask

   task automatic test_basic();
      int lat;
      run_op(16'h1234, 16'h4321, 1'b0, lat);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL basic_latency: got %0d, required %0d", lat, LAT); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_width: got done=%b, required 0", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle: got %b, required 0", bus.busy); end
      checks++; if (bus.sum !== 16'h5555) begin failures++; $display("FAIL basic_sum_hold: got %h, required 5555", bus.sum); end
   endtask

   task automatic test_carry_ripple();
      int lat;
      run_op(16'hFFFF, 16'h0001, 1'b0, lat);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL ripple_latency: got %0d, required %0d", lat, LAT); end
      checks++; if ({bus.c_out, bus.sum} !== 17'h1_0000) begin
         failures++; $display("FAIL ripple_hold: got c_out=%b sum=%h, required 1 0000", bus.c_out, bus.sum);
      end
   endtask

   task automatic test_overflow();
      int lat;
      run_op(16'h7FFF, 16'h0001, 1'b0, lat);
      checks++; if ({bus.ovf, bus.c_out, bus.sum} !== {1'b1, 1'b0, 16'h8000}) begin
         failures++; $display("FAIL ovf_pos: got ovf=%b c_out=%b sum=%h, required 1 0 8000", bus.ovf, bus.c_out, bus.sum);
      end
      run_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
      checks++; if ({bus.ovf, bus.c_out, bus.sum} !== {1'b0, 1'b1, 16'hFFFF}) begin
         failures++; $display("FAIL ovf_cin: got ovf=%b c_out=%b sum=%h, required 0 1 ffff", bus.ovf, bus.c_out, bus.sum);
      end
      run_op(16'h8000, 16'h8000, 1'b0, lat);
      checks++; if ({bus.ovf, bus.c_out, bus.sum} !== {1'b1, 1'b1, 16'h0000}) begin
         failures++; $display("FAIL ovf_neg: got ovf=%b c_out=%b sum=%h, required 1 1 0000", bus.ovf, bus.c_out, bus.sum);
      end
   endtask

   task automatic test_ignore_start();
      int d0 = done_cnt;
      int n  = 0;
      launch(16'h0102, 16'h0304, 1'b0);
      @(negedge clk);
      bus.start = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 16'hAAAA;
      while (bus.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
         bus.b = W'($urandom);
      end
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL ignore_timeout: got no done, required done"); end
      bus.start = 1'b1; bus.a = 16'h5555; bus.b = 16'h5555;   // start during the done cycle
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_busy: got busy=%b at idle cycle %0d, required 0", bus.busy, i); end
         @(negedge clk);
      end
      checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d, required 1", done_cnt - d0); end
      checks++; if (bus.sum !== 16'h0406) begin failures++; $display("FAIL ignore_sum: got %h, required 0406", bus.sum); end
   endtask

   task automatic test_async_reset();
      int d0 = done_cnt;
      int lat;
      launch(16'h1111, 16'h2222, 1'b0);
      repeat (3) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      // Nibbles 0 and 1 are written, index now points at nibble 2.
      checks++; if (bus.sum !== 16'h0033 || bus.busy !== 1'b1) begin
         failures++; $display("FAIL areset_midop: got sum=%h busy=%b, required 0033 1", bus.sum, bus.busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL areset_busy: got %b, required 0", bus.busy); end
      checks++; if (bus.sum !== '0) begin failures++; $display("FAIL areset_sum: got %h, required 0", bus.sum); end
      exp_q.delete();
      repeat (3) @(negedge clk);
      checks++; if (done_cnt !== d0) begin failures++; $display("FAIL areset_no_done: got %0d pulses, required 0", done_cnt - d0); end
      reset = 1'b0;
      run_op(16'h0003, 16'h0004, 1'b0, lat);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL areset_restart_latency: got %0d, required %0d", lat, LAT); end
      checks++; if (bus.sum !== 16'h0007) begin failures++; $display("FAIL areset_restart_sum: got %h, required 0007", bus.sum); end
   endtask

   task automatic test_back_to_back();
      int last_done = -1;
      int low_run   = 0;
      int n_done    = 0;
      int n         = 0;
      bus.start = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (bus.done === 1'b1) begin
            n_done++;
            if (last_done >= 0) begin
               checks++; if (cyc - last_done !== PERIOD) begin
                  failures++; $display("FAIL b2b_period: got %0d cycles, required %0d", cyc - last_done, PERIOD);
               end
            end
            last_done = cyc;
         end
         if (bus.busy === 1'b0) begin
            low_run++;
         end else begin
            if (low_run > 0) begin
               checks++; if (low_run !== 1) begin failures++; $display("FAIL b2b_idle_gap: got %0d idle cycles, required 1", low_run); end
            end
            low_run = 0;
         end
         bus.a    = W'($urandom);
         bus.b    = W'($urandom);
         bus.c_in = 1'($urandom);
         if (bus.busy === 1'b0) exp_q.push_back(model(bus.a, bus.b, bus.c_in));
         @(negedge clk);
      end
      bus.start = 1'b0;
      checks++; if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d, required 3", n_done); end
      while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_random();
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), lat);
         checks++; if (lat !== LAT) begin failures++; $display("FAIL random_latency: got %0d, required %0d (op %0d)", lat, LAT, i); end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL random_pending: got %0d, required 0", exp_q.size()); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.c_in  = 1'b0;
      test_reset();
      test_basic();
      test_carry_ripple();
      test_overflow();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
